// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake and operand/result bus for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 4);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Diff;
   logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif
   modport master (
      output start, A, B, Bin,
      input  busy, done, Diff, Bout
`ifdef SERIAL_SUB_OVF_EN
      , input ovf
`endif
   );
   modport slave (
      input  start, A, B, Bin,
      output busy, done, Diff, Bout
`ifdef SERIAL_SUB_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, LSB first, one bit per clock behind a start/done handshake.
// Defining SERIAL_SUB_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_t           state, state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr, shifted, diff_r;
   logic [WIDTH-2:0] res;
   logic             br, br_next, d, last, bout_r;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_r;
   assign bus.ovf = ovf_r;
`endif
   assign bus.busy = state == RUN;
   assign bus.done = state == DONE;
   assign bus.Diff = diff_r;
   assign bus.Bout = bout_r;
   // one full-subtractor step on the current LSBs; shifted is the result register with d entered MSB-side
   always_comb begin
      d       = a_sr[0] ^ b_sr[0] ^ br;
      br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      shifted = {d, res};
      last    = cnt == LAST;
   end
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_next;
   // next state: start is honoured only in IDLE, DONE lasts exactly one cycle
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = bus.start ? RUN : IDLE;
         RUN:     state_next = last ? DONE : RUN;
         default: state_next = IDLE;
      endcase
   end
   // operand capture, bit-serial datapath, and result registers updated only at the completion edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res    <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff_r <= '0;
         bout_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_r  <= 1'b0;
`endif
      end else if (state == IDLE && bus.start) begin
         a_sr <= bus.A;
         b_sr <= bus.B;
         br   <= bus.Bin;
         res  <= '0;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         res  <= shifted[WIDTH-1:1];
         br   <= br_next;
         cnt  <= cnt + 1'b1;
         if (last) begin
            diff_r <= shifted;
            bout_r <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r  <= br ^ br_next;
`endif
         end
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven, hand-written and randomized checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic [W-1:0] prev_diff = '0;
   logic         prev_bout = 1'b0;
   serial_subtractor_if #(.WIDTH(W)) bus ();
   serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } vec_t;
   vec_t vecs [11];
   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   // plain integer arithmetic: unsigned difference, borrow, signed overflow
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] d, output logic bo, output logic ov);
      int r, sa, sb, rs;
      r  = int'(a) - int'(b) - int'(bin);
      d  = W'(r);
      bo = r < 0;
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
      rs = sa - sb - int'(bin);
      ov = rs < -(1 << (W - 1)) || rs > (1 << (W - 1)) - 1;
   endtask
   // issue one operation; optionally scramble inputs and pulse start while RUN is in progress
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input bit scramble, input string name);
      int n = 0;
      int busy_bad = 0;
      int hold_bad = 0;
      @(negedge clk);
      bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (!bus.done && n < 20) begin
         if (!bus.busy) busy_bad++;
         if (bus.Diff != prev_diff || bus.Bout != prev_bout) hold_bad++;
         if (scramble) begin
            bus.A = W'($urandom); bus.B = W'($urandom); bus.Bin = 1'($urandom); bus.start = 1'($urandom);
         end
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
      check({name, " run_cycles"}, n, W);
      check({name, " busy_in_run"}, busy_bad, 0);
      check({name, " result_held"}, hold_bad, 0);
      check({name, " busy_at_done"}, int'(bus.busy), 0);
      check({name, " diff"}, int'(bus.Diff), int'(ed));
      check({name, " bout"}, int'(bus.Bout), int'(eb));
`ifdef SERIAL_SUB_OVF_EN
      check({name, " ovf"}, int'(bus.ovf), int'(eo));
`else
      if (eo === 1'bx) $display("unexpected X ovf in %s", name);
`endif
      @(negedge clk);
      check({name, " done_one_cycle"}, int'(bus.done), 0);
      prev_diff = ed;
      prev_bout = eb;
   endtask
   initial begin
      logic [W-1:0] md, ra, rb;
      logic mb, mo, rbin;
      int dones;
      vecs[0]  = '{4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0};
      vecs[1]  = '{4'b0001, 4'b0010, 1'b0, 4'b1111, 1'b1, 1'b0};
      vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[3]  = '{4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b0};
      vecs[4]  = '{4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0, 1'b1};
      vecs[5]  = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
      vecs[6]  = '{4'b0111, 4'b0001, 1'b0, 4'b0110, 1'b0, 1'b0};
      vecs[7]  = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[8]  = '{4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1};
      vecs[9]  = '{4'b0000, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1};
      vecs[10] = '{4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0};
      bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
      repeat (2) @(negedge clk);
      check("reset busy", int'(bus.busy), 0);
      check("reset done", int'(bus.done), 0);
      check("reset diff", int'(bus.Diff), 0);
      check("reset bout", int'(bus.Bout), 0);
`ifdef SERIAL_SUB_OVF_EN
      check("reset ovf", int'(bus.ovf), 0);
`endif
      rst = 1'b0;
      for (int i = 0; i < 11; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf, 0, $sformatf("vec%0d", i));
      run_op(4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b0, 1, "ignore_start");
      run_op(4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0, 1'b1, 1, "scramble");
      @(negedge clk);
      bus.A = 4'b1001; bus.B = 4'b0010; bus.Bin = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrun_rst busy", int'(bus.busy), 0);
      check("midrun_rst diff", int'(bus.Diff), 0);
      check("midrun_rst bout", int'(bus.Bout), 0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("midrun_rst no_done", dones, 0);
      prev_diff = '0;
      prev_bout = 1'b0;
      run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 0, "after_rst");
      @(negedge clk);
      bus.A = 4'b0110; bus.B = 4'b0001; bus.Bin = 1'b0; bus.start = 1'b1;
      dones = 0;
      repeat (3 * (W + 2)) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      bus.start = 1'b0;
      check("held_start done_count", dones, 3);
      check("held_start diff", int'(bus.Diff), 5);
      prev_diff = 4'b0101;
      prev_bout = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
         model(ra, rb, rbin, md, mb, mo);
         run_op(ra, rb, rbin, md, mb, mo, i[0], $sformatf("rand%0d", i));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
